// File: rtl/mm_job_sequencer.sv
// Per-job controller for the matrix-multiply output path: accepts a job descriptor,
// derives the datapath size words, sequences multiply and drain, and checks the output stream.
module mm_job_sequencer #(
  parameter int N1           = 4,
  parameter int N2           = 4,
  parameter int MATRIXSIZE_W = 16,
  parameter int TIMEOUT_W    = 20
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [MATRIXSIZE_W-1:0]   cfg_M1,
  input  logic [MATRIXSIZE_W-1:0]   cfg_M2,
  input  logic [MATRIXSIZE_W-1:0]   cfg_M3,
  output logic [MATRIXSIZE_W-1:0]   M2,
  output logic [MATRIXSIZE_W-1:0]   M3,
  output logic [MATRIXSIZE_W-1:0]   M1dN1,
  output logic [MATRIXSIZE_W-1:0]   M1xM3dN1,
  output logic                      start_multiply,
  input  logic                      done_multiply_sync,
  output logic                      start_read_s2v,
  input  logic                      mon_tvalid,
  input  logic                      mon_tready,
  input  logic                      mon_tlast,
  output logic                      busy,
  output logic                      job_done,
  output logic                      err_cfg,
  output logic                      err_tlast,
  output logic                      err_timeout,
  output logic [2*MATRIXSIZE_W-1:0] beat_count
);

  localparam int LOG2N1 = $clog2(N1);
  localparam int BW     = 2 * MATRIXSIZE_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_PREV,
    S_COMPUTE,
    S_DRAIN,
    S_FINISH
  } state_t;

  state_t                  state_q, state_d;
  logic [MATRIXSIZE_W-1:0] m1_q, m2_q, m3_q;
  logic [MATRIXSIZE_W-1:0] m1dn1_q, m1xm3dn1_q;
  logic [BW-1:0]           exp_beats_q;
  logic [BW-1:0]           beat_q;
  logic [TIMEOUT_W-1:0]    wd_q;
  logic                    start_q;
  logic                    err_cfg_q, err_tlast_q, err_timeout_q;

  logic                    accept, legal, accept_legal;
  logic                    beat, last_beat, wd_expired, in_watch;
  logic [BW-1:0]           beat_nxt;
  logic [MATRIXSIZE_W-1:0] m1_div;
  logic [BW-1:0]           m1div_x_m3;
  logic [BW-1:0]           m1_x_m3;

  function automatic logic cfg_legal(input logic [MATRIXSIZE_W-1:0] m1,
                                     input logic [MATRIXSIZE_W-1:0] m2,
                                     input logic [MATRIXSIZE_W-1:0] m3);
    logic [MATRIXSIZE_W-1:0] mask1, mask2;
    mask1 = MATRIXSIZE_W'(N1 - 1);
    mask2 = MATRIXSIZE_W'(N2 - 1);
    return (m1 != '0) && (m2 != '0) && (m3 != '0) &&
           ((m1 & mask1) == '0) && ((m3 & mask2) == '0);
  endfunction

  assign accept       = cfg_valid && cfg_ready;
  assign legal        = cfg_legal(cfg_M1, cfg_M2, cfg_M3);
  assign accept_legal = accept && legal;

  assign m1_div     = m1_q >> LOG2N1;
  assign m1div_x_m3 = BW'(m1_div) * BW'(m3_q);
  assign m1_x_m3    = BW'(m1_q) * BW'(m3_q);

  // Beats only count while draining; a beat in COMPUTE (even alongside done) is dropped.
  assign beat      = (state_q == S_DRAIN) && mon_tvalid && mon_tready;
  assign beat_nxt  = beat_q + BW'(1);
  assign last_beat = beat && (beat_nxt == exp_beats_q);

  assign in_watch   = (state_q == S_COMPUTE) || (state_q == S_DRAIN);
  assign wd_expired = in_watch && (wd_q == '1) && !beat &&
                      !((state_q == S_COMPUTE) && done_multiply_sync);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (accept_legal) state_d = S_LOAD;
      S_LOAD:      state_d = S_WAIT_PREV;
      S_WAIT_PREV: if (!done_multiply_sync) state_d = S_COMPUTE;
      S_COMPUTE: begin
        if (wd_expired)              state_d = S_IDLE;
        else if (done_multiply_sync) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (last_beat)       state_d = S_FINISH;
        else if (wd_expired) state_d = S_IDLE;
      end
      S_FINISH:    state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      start_q       <= 1'b0;
      err_cfg_q     <= 1'b0;
      err_tlast_q   <= 1'b0;
      err_timeout_q <= 1'b0;
      wd_q          <= '0;
      beat_q        <= '0;
    end else begin
      state_q   <= state_d;
      start_q   <= (state_d == S_COMPUTE) && (state_q != S_COMPUTE);
      err_cfg_q <= accept && !legal;

      if (accept_legal)
        err_tlast_q <= 1'b0;
      else if (beat && (mon_tlast != (beat_nxt == exp_beats_q)))
        err_tlast_q <= 1'b1;

      if (accept_legal)    err_timeout_q <= 1'b0;
      else if (wd_expired) err_timeout_q <= 1'b1;

      // Watchdog restarts on every state change and on every accepted beat.
      if ((state_d != state_q) || beat) wd_q <= '0;
      else if (in_watch && (wd_q != '1)) wd_q <= wd_q + TIMEOUT_W'(1);

      if (accept_legal)              beat_q <= '0;
      else if (beat && beat_q != '1) beat_q <= beat_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m1_q        <= '0;
      m2_q        <= '0;
      m3_q        <= '0;
      m1dn1_q     <= '0;
      m1xm3dn1_q  <= '0;
      exp_beats_q <= '0;
    end else begin
      if (accept_legal) begin
        m1_q <= cfg_M1;
        m2_q <= cfg_M2;
        m3_q <= cfg_M3;
      end
      if (state_q == S_LOAD) begin
        m1dn1_q     <= m1_div;
        m1xm3dn1_q  <= m1div_x_m3[MATRIXSIZE_W-1:0];
        exp_beats_q <= m1_x_m3;
      end
    end
  end

  assign cfg_ready      = (state_q == S_IDLE);
  assign busy           = (state_q != S_IDLE);
  assign start_read_s2v = (state_q == S_DRAIN);
  assign job_done       = (state_q == S_FINISH);
  assign start_multiply = start_q;
  assign err_cfg        = err_cfg_q;
  assign err_tlast      = err_tlast_q;
  assign err_timeout    = err_timeout_q;
  assign beat_count     = beat_q;
  assign M2             = m2_q;
  assign M3             = m3_q;
  assign M1dN1          = m1dn1_q;
  assign M1xM3dN1       = m1xm3dn1_q;

endmodule

// File: tb/tb_mm_job_sequencer.sv
// Directed bench for mm_job_sequencer: runs legal/illegal jobs, tlast errors,
// backpressure, watchdog expiry and mid-job reset against a beat-count scoreboard.
module tb_mm_job_sequencer;

  localparam int W  = 16;
  localparam int BW = 2 * W;

  logic          clk, rst;
  logic          cfg_valid, cfg_ready;
  logic [W-1:0]  cfg_M1, cfg_M2, cfg_M3;
  logic [W-1:0]  M2, M3, M1dN1, M1xM3dN1;
  logic          start_multiply, done_multiply_sync, start_read_s2v;
  logic          mon_tvalid, mon_tready, mon_tlast;
  logic          busy, job_done, err_cfg, err_tlast, err_timeout;
  logic [BW-1:0] beat_count;

  int total = 0;
  int bad   = 0;
  logic [BW-1:0] sbq[$];

  mm_job_sequencer #(.N1(4), .N2(4), .MATRIXSIZE_W(W), .TIMEOUT_W(4)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_M1(cfg_M1), .cfg_M2(cfg_M2), .cfg_M3(cfg_M3),
    .M2(M2), .M3(M3), .M1dN1(M1dN1), .M1xM3dN1(M1xM3dN1),
    .start_multiply(start_multiply), .done_multiply_sync(done_multiply_sync),
    .start_read_s2v(start_read_s2v),
    .mon_tvalid(mon_tvalid), .mon_tready(mon_tready), .mon_tlast(mon_tlast),
    .busy(busy), .job_done(job_done), .err_cfg(err_cfg), .err_tlast(err_tlast),
    .err_timeout(err_timeout), .beat_count(beat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL sim_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_cfg(input int m1, input int m2, input int m3);
    chk("cfg_ready_before", cfg_ready, 1);
    cfg_valid = 1'b1;
    cfg_M1    = W'(m1);
    cfg_M2    = W'(m2);
    cfg_M3    = W'(m3);
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic check_illegal(input int m1, input int m2, input int m3,
                               input int pm2, input int pm3, input int pd, input int pdx);
    do_cfg(m1, m2, m3);
    chk("illegal_err_cfg", err_cfg, 1);
    chk("illegal_busy", busy, 0);
    chk("illegal_M2_held", M2, pm2);
    chk("illegal_M3_held", M3, pm3);
    chk("illegal_M1dN1_held", M1dN1, pd);
    chk("illegal_M1xM3dN1_held", M1xM3dN1, pdx);
    tick();
    chk("illegal_err_cfg_pulse", err_cfg, 0);
    chk("illegal_busy_later", busy, 0);
  endtask

  task automatic run_job(input int m1, input int m2, input int m3, input int early,
                         input bit bp, input int abort_at, input bit prev_done);
    int  expn, hs_cnt, cyc;
    bit  hs, errm;
    expn = m1 * m3;
    done_multiply_sync = prev_done;
    do_cfg(m1, m2, m3);
    chk("load_busy", busy, 1);
    chk("load_err_cfg", err_cfg, 0);
    chk("load_M2", M2, m2);
    chk("load_M3", M3, m3);
    chk("load_beat_count_clear", beat_count, 0);
    tick();
    chk("derived_M1dN1", M1dN1, m1 / 4);
    chk("derived_M1xM3dN1", M1xM3dN1, ((m1 / 4) * m3) & 16'hFFFF);
    tick();
    if (prev_done) begin
      chk("wait_prev_no_start", start_multiply, 0);
      done_multiply_sync = 1'b0;
      tick();
    end
    chk("start_pulse", start_multiply, 1);
    chk("start_read_low_compute", start_read_s2v, 0);
    tick();
    chk("start_pulse_end", start_multiply, 0);
    done_multiply_sync = 1'b1;
    mon_tvalid = 1'b1;
    mon_tready = 1'b1;
    mon_tlast  = 1'b0;
    tick();
    chk("compute_beat_ignored", beat_count, 0);
    chk("drain_read_en", start_read_s2v, 1);
    done_multiply_sync = 1'b0;

    hs_cnt = 0;
    cyc    = 0;
    errm   = 1'b0;
    while (hs_cnt < expn) begin
      hs = bp ? (cyc % 2 == 0) : 1'b1;
      cyc++;
      mon_tvalid = 1'b1;
      mon_tready = hs;
      if (hs) begin
        hs_cnt++;
        mon_tlast = (hs_cnt == early) || (hs_cnt == expn);
        if (mon_tlast != (hs_cnt == expn)) errm = 1'b1;
      end else begin
        mon_tlast = 1'b1;
      end
      sbq.push_back(BW'(hs_cnt));
      tick();
      chk("beat_count", beat_count, sbq.pop_front());
      if (hs && early != 0 && hs_cnt == early) chk("err_tlast_early", err_tlast, 1);
      if (abort_at != 0 && hs_cnt == abort_at) break;
    end
    mon_tvalid = 1'b0;
    mon_tready = 1'b0;
    mon_tlast  = 1'b0;
    if (abort_at != 0) return;

    chk("finish_job_done", job_done, 1);
    chk("finish_read_dropped", start_read_s2v, 0);
    chk("finish_err_tlast", err_tlast, errm);
    tick();
    chk("idle_job_done_pulse", job_done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_cfg_ready", cfg_ready, 1);
    chk("final_beat_count", beat_count, expn);
    chk("final_err_timeout", err_timeout, 0);
  endtask

  initial begin
    rst = 1'b1;
    cfg_valid = 1'b0;
    cfg_M1 = '0;
    cfg_M2 = '0;
    cfg_M3 = '0;
    done_multiply_sync = 1'b0;
    mon_tvalid = 1'b0;
    mon_tready = 1'b0;
    mon_tlast  = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_M1dN1", M1dN1, 0);
    chk("rst_M3", M3, 0);
    chk("rst_beat_count", beat_count, 0);
    chk("rst_start_multiply", start_multiply, 0);
    chk("rst_errors", {err_cfg, err_tlast, err_timeout}, 0);
    tick();

    // Nominal job
    run_job(8, 4, 8, 0, 1'b0, 0, 1'b0);

    // Rejected descriptors leave previous job's words intact
    check_illegal(6, 9, 8, 4, 8, 2, 16);
    check_illegal(8, 4, 6, 4, 8, 2, 16);
    check_illegal(8, 0, 8, 4, 8, 2, 16);
    chk("illegal_beat_count_held", beat_count, 64);

    // Early tlast at beat 10
    run_job(8, 4, 8, 10, 1'b0, 0, 1'b0);

    // Backpressure with done still high from previous job
    run_job(8, 4, 8, 0, 1'b1, 0, 1'b1);
    chk("bp_err_tlast_cleared", err_tlast, 0);

    // Watchdog: multiply never completes
    do_cfg(4, 4, 4);
    tick();
    tick();
    chk("wd_start", start_multiply, 1);
    repeat (15) tick();
    chk("wd_not_yet", err_timeout, 0);
    chk("wd_still_busy", busy, 1);
    tick();
    chk("wd_err_timeout", err_timeout, 1);
    chk("wd_idle", busy, 0);
    chk("wd_cfg_ready", cfg_ready, 1);
    chk("wd_no_job_done", job_done, 0);
    tick();
    chk("wd_sticky", err_timeout, 1);

    // Reset at beat 20 of a drain
    run_job(8, 4, 8, 0, 1'b0, 20, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_cfg_ready", cfg_ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_read", start_read_s2v, 0);
    chk("abort_beat_count", beat_count, 0);
    chk("abort_sizes", {M2, M3, M1dN1, M1xM3dN1}, 0);
    chk("abort_flags", {start_multiply, job_done, err_cfg, err_tlast, err_timeout}, 0);
    run_job(12, 4, 4, 0, 1'b0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
